// File: rtl/rfphoenix_mem_req_sequencer_pkg.sv
// Shared types for the memory request sequencer: request entry layout,
// thread count and the sequencer FSM encoding.
package rfphoenix_mem_req_sequencer_pkg;

    localparam int NTHREADS = 4;
    localparam int TW       = $clog2(NTHREADS);
    localparam int AW       = 32;
    localparam int DW       = 32;

    typedef enum logic [1:0] {
        MR_LOAD  = 2'd0,
        MR_STORE = 2'd1,
        MR_LOADZ = 2'd2,
        MR_NOP   = 2'd3
    } memop_t;

    typedef struct packed {
        logic          v;
        logic [TW-1:0] thread;
        memop_t        func;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [DW-1:0] res;
    } memory_arg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        POP  = 2'd2,
        RESP = 2'd3
    } mrs_state_t;

    // Completed request: the issued entry with its result field replaced.
    function automatic memory_arg_t mrs_with_res(input memory_arg_t a, input logic [DW-1:0] r);
        memory_arg_t o;
        o     = a;
        o.res = r;
        return o;
    endfunction

endpackage

// File: rtl/rfphoenix_mem_req_sequencer_if.sv
// Queue-head, memory-port, rollback and writeback-response signals of the
// sequencer; master is the sequencer side, slave is its environment.
interface rfphoenix_mem_req_sequencer_if;
    import rfphoenix_mem_req_sequencer_pkg::*;

    logic                q_valid;
    memory_arg_t         q_head;
    logic                q_rd;
    logic                mem_req;
    memory_arg_t         mem_arg;
    logic                mem_ack;
    logic [DW-1:0]       mem_res;
    logic [NTHREADS-1:0] rollback;
    logic                resp_v;
    memory_arg_t         resp;
    logic                resp_err;
    logic                resp_rdy;
    logic                busy;

    modport master (
        input  q_valid, q_head, mem_ack, mem_res, rollback, resp_rdy,
        output q_rd, mem_req, mem_arg, resp_v, resp, resp_err, busy
    );

    modport slave (
        output q_valid, q_head, mem_ack, mem_res, rollback, resp_rdy,
        input  q_rd, mem_req, mem_arg, resp_v, resp, resp_err, busy
    );

endinterface

// File: rtl/rfphoenix_mem_req_sequencer.sv
// Drains the memory request queue one head entry at a time onto the data
// memory port, with drop, in-flight squash and bus-timeout handling.
module rfphoenix_mem_req_sequencer
    import rfphoenix_mem_req_sequencer_pkg::*;
#(
    parameter int TMO = 63
) (
    input  logic                           clk,
    input  logic                           rst,
    rfphoenix_mem_req_sequencer_if.master  bus
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    mrs_state_t  r_state;
    logic [7:0]  r_tcnt;
    logic        r_sq;
    logic        r_err;
    logic        r_drop;
    logic        r_q_rd;
    logic        r_mem_req;
    logic        r_resp_v;
    logic        r_resp_err;
    memory_arg_t r_mem_arg;
    memory_arg_t r_resp;

    logic        w_head_rb;
    logic        w_arg_rb;
    logic        w_tmo;

    assign w_head_rb = bus.rollback[bus.q_head.thread];
    assign w_arg_rb  = bus.rollback[r_mem_arg.thread];
    assign w_tmo     = (r_tcnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_tcnt     <= '0;
            r_sq       <= 1'b0;
            r_err      <= 1'b0;
            r_drop     <= 1'b0;
            r_q_rd     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_resp_v   <= 1'b0;
            r_resp_err <= 1'b0;
            r_mem_arg  <= '0;
            r_resp     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.q_valid) begin
                        if (!bus.q_head.v || w_head_rb) begin
                            r_drop  <= 1'b1;
                            r_q_rd  <= 1'b1;
                            r_state <= POP;
                        end else begin
                            r_mem_arg <= bus.q_head;
                            r_mem_req <= 1'b1;
                            r_tcnt    <= '0;
                            r_sq      <= 1'b0;
                            r_err     <= 1'b0;
                            r_drop    <= 1'b0;
                            r_state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_tcnt <= r_tcnt + 8'd1;
                    if (w_arg_rb) begin
                        r_sq <= 1'b1;
                    end
                    // An ack on the terminal count cycle still completes normally.
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_resp    <= mrs_with_res(r_mem_arg, bus.mem_res);
                        r_q_rd    <= 1'b1;
                        r_state   <= POP;
                    end else if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_resp    <= mrs_with_res(r_mem_arg, '0);
                        r_q_rd    <= 1'b1;
                        r_state   <= POP;
                    end
                end
                POP: begin
                    r_q_rd <= 1'b0;
                    if (w_arg_rb) begin
                        r_sq <= 1'b1;
                    end
                    if (r_drop || r_sq || w_arg_rb) begin
                        r_drop  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_resp_v   <= 1'b1;
                        r_resp_err <= r_err;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_rdy) begin
                        r_resp_v   <= 1'b0;
                        r_resp_err <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.q_rd     = r_q_rd;
    assign bus.mem_req  = r_mem_req;
    assign bus.mem_arg  = r_mem_arg;
    assign bus.resp_v   = r_resp_v;
    assign bus.resp     = r_resp;
    assign bus.resp_err = r_resp_err;
    assign bus.busy     = (r_state != IDLE);

endmodule
